// File: rtl/tt_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tt_pattern_sequencer
// One-shot / looping run sequencer for a TinyTapeout tile. A start pulse
// captures a data word and launches a RUN_LEN-cycle run during which a
// preset serial pattern is rotated out MSB-first. At the end of a run the
// captured word is presented on data_out together with a done flag that is
// sticky in one-shot mode and a single-cycle pulse in loop mode.
// ---------------------------------------------------------------------------
module tt_pattern_sequencer #(
   parameter int                    DATA_W   = 6,
   parameter int                    CNT_W    = 6,
   parameter int                    RUN_LEN  = 46,
   parameter int                    PAT_LEN  = 16,
   parameter logic [PAT_LEN-1:0]    PAT_INIT = 16'h0300
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              loop_mode,
   input  logic [DATA_W-1:0] data_in,
   output logic              ser_out,
   output logic              running,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] data_out
);

   // Terminal count of a run and the increment step, sized to the counter.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   // Explicit 2-bit encoding; the spare code 2'b11 recovers to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // -------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------
   state_t              state_reg,   state_next;
   logic [CNT_W-1:0]    count_reg,   count_next;
   logic [PAT_LEN-1:0]  pat_reg,     pat_next;
   logic [DATA_W-1:0]   capture_reg, capture_next;
   logic [DATA_W-1:0]   data_out_reg, data_out_next;
   logic                done_reg,    done_next;
   logic                running_reg;

   // Pattern register rotated left by one position (MSB wraps into bit 0).
   logic [PAT_LEN-1:0]  pat_rot;

   // Terminal-count decode used by the RUN state.
   logic                at_last;

   // -------------------------------------------------------------------
   // Rotate-left network, one wire per pattern bit
   // -------------------------------------------------------------------
   assign pat_rot[0] = pat_reg[PAT_LEN-1];

   generate
      for (genvar gi = 1; gi < PAT_LEN; gi++) begin : g_rot
         assign pat_rot[gi] = pat_reg[gi-1];
      end
   endgenerate

   assign at_last = (count_reg == LAST_CNT);

   // -------------------------------------------------------------------
   // Next-state and datapath decode; abort overrides every other action
   // -------------------------------------------------------------------
   always_comb begin
      // Defaults: hold everything.
      state_next    = state_reg;
      count_next    = count_reg;
      pat_next      = pat_reg;
      capture_next  = capture_reg;
      data_out_next = data_out_reg;
      done_next     = done_reg;

      if (abort) begin
         // Abandon whatever is happening; data_out keeps the last result.
         state_next = ST_IDLE;
         count_next = CNT_ZERO;
         pat_next   = PAT_INIT;
         done_next  = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_next   = ST_RUN;
                  capture_next = data_in;
                  count_next   = CNT_ZERO;
                  pat_next     = PAT_INIT;
                  done_next    = 1'b0;
               end
            end

            ST_RUN: begin
               if (start) begin
                  // Restart: fresh capture and run; previous result stays on data_out.
                  capture_next = data_in;
                  count_next   = CNT_ZERO;
                  pat_next     = PAT_INIT;
                  done_next    = 1'b0;
               end else if (at_last) begin
                  // End of run: publish the captured word and raise done.
                  data_out_next = capture_reg;
                  done_next     = 1'b1;
                  if (loop_mode) begin
                     // Begin the next run straight away; done becomes a pulse.
                     count_next = CNT_ZERO;
                     pat_next   = PAT_INIT;
                  end else begin
                     // Freeze count and pattern where they are.
                     state_next = ST_DONE;
                  end
               end else begin
                  count_next = count_reg + CNT_ONE;
                  pat_next   = pat_rot;
                  // Clears the single-cycle done pulse after a loop wrap.
                  done_next  = 1'b0;
               end
            end

            ST_DONE: begin
               if (start) begin
                  state_next   = ST_RUN;
                  capture_next = data_in;
                  count_next   = CNT_ZERO;
                  pat_next     = PAT_INIT;
                  done_next    = 1'b0;
               end
            end

            default: begin
               // Unused encoding: fall back to a clean idle.
               state_next = ST_IDLE;
               count_next = CNT_ZERO;
               pat_next   = PAT_INIT;
               done_next  = 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------
   // State register with asynchronous reset
   // -------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath registers: counter, pattern, capture, result and done flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg    <= CNT_ZERO;
         pat_reg      <= PAT_INIT;
         capture_reg  <= '0;
         data_out_reg <= '0;
         done_reg     <= 1'b0;
      end else begin
         count_reg    <= count_next;
         pat_reg      <= pat_next;
         capture_reg  <= capture_next;
         data_out_reg <= data_out_next;
         done_reg     <= done_next;
      end
   end

   // running is a registered decode of the next state, so it tracks state_reg==RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running_reg <= 1'b0;
      end else begin
         running_reg <= (state_next == ST_RUN);
      end
   end

   // -------------------------------------------------------------------
   // Outputs come straight from registers
   // -------------------------------------------------------------------
   assign ser_out  = pat_reg[PAT_LEN-1];
   assign running  = running_reg;
   assign done     = done_reg;
   assign count    = count_reg;
   assign data_out = data_out_reg;

endmodule

// File: tb/tb_tt_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tt_pattern_sequencer
// Directed bench: one-shot run, serial pattern, loop mode, restart,
// abort-vs-start priority and asynchronous reset mid-run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tt_pattern_sequencer;

   localparam int RUN_LEN = 46;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic       loop_mode;
   logic [5:0] data_in;
   logic       ser_out;
   logic       running;
   logic       done;
   logic [5:0] count;
   logic [5:0] data_out;

   int n_checks = 0;
   int n_errors = 0;

   tt_pattern_sequencer #(
      .DATA_W   (6),
      .CNT_W    (6),
      .RUN_LEN  (RUN_LEN),
      .PAT_LEN  (16),
      .PAT_INIT (16'h0300)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .loop_mode (loop_mode),
      .data_in   (data_in),
      .ser_out   (ser_out),
      .running   (running),
      .done      (done),
      .count     (count),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected ser_out k cycles after a pattern load: 0300 read MSB-first, period 16.
   function automatic logic exp_ser(input int k);
      logic [15:0] p;
      p = 16'h0300;
      return p[15 - (k % 16)];
   endfunction

   // One-shot run from IDLE/DONE; prior_out is data_out before the run ends.
   task automatic run_oneshot(input logic [5:0] word, input logic [5:0] prior_out);
      loop_mode = 1'b0;
      data_in   = word;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      data_in   = 6'h00;
      for (int k = 0; k < RUN_LEN; k++) begin
         check("os_count",   32'(count),    32'(k));
         check("os_running", 32'(running),  32'd1);
         check("os_done",    32'(done),     32'd0);
         check("os_ser",     32'(ser_out),  32'(exp_ser(k)));
         check("os_dout",    32'(data_out), 32'(prior_out));
         tick();
      end
      check("os_end_done",  32'(done),     32'd1);
      check("os_end_dout",  32'(data_out), 32'(word));
      check("os_end_run",   32'(running),  32'd0);
      check("os_end_count", 32'(count),    32'(RUN_LEN - 1));
      for (int k = 0; k < 3; k++) begin
         tick();
         check("os_hold_count", 32'(count),   32'(RUN_LEN - 1));
         check("os_hold_done",  32'(done),    32'd1);
         check("os_hold_run",   32'(running), 32'd0);
         check("os_hold_ser",   32'(ser_out), 32'(exp_ser(RUN_LEN - 1)));
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      loop_mode = 1'b0;
      data_in   = 6'h00;

      // Reset state while rst is held.
      #2;
      check("rst_count",   32'(count),    32'd0);
      check("rst_running", 32'(running),  32'd0);
      check("rst_done",    32'(done),     32'd0);
      check("rst_dout",    32'(data_out), 32'd0);
      check("rst_ser",     32'(ser_out),  32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("idle_running", 32'(running), 32'd0);
      check("idle_count",   32'(count),   32'd0);

      // Scenario 1/2: one-shot run with 2A, pattern checked every cycle.
      run_oneshot(6'h2A, 6'h00);

      // Scenario 3: loop mode with 15; done pulses at t=46 and t=92.
      loop_mode = 1'b1;
      data_in   = 6'h15;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      data_in   = 6'h00;
      for (int t = 0; t < 112; t++) begin
         check("lp_count",   32'(count),    32'(t % RUN_LEN));
         check("lp_done",    32'(done),     32'((t > 0) && (t % RUN_LEN == 0)));
         check("lp_running", 32'(running),  32'd1);
         check("lp_ser",     32'(ser_out),  32'(exp_ser(t % RUN_LEN)));
         check("lp_dout",    32'(data_out), (t < RUN_LEN) ? 32'h2A : 32'h15);
         tick();
      end

      // Scenario 4: restart at count 20 with 07, one-shot from here.
      check("rs_pre_count", 32'(count), 32'd20);
      loop_mode = 1'b0;
      data_in   = 6'h07;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      data_in   = 6'h00;
      for (int k = 0; k < RUN_LEN; k++) begin
         check("rs_count", 32'(count),    32'(k));
         check("rs_done",  32'(done),     32'd0);
         check("rs_dout",  32'(data_out), 32'h15);
         check("rs_ser",   32'(ser_out),  32'(exp_ser(k)));
         tick();
      end
      check("rs_end_done",  32'(done),     32'd1);
      check("rs_end_dout",  32'(data_out), 32'h07);
      check("rs_end_count", 32'(count),    32'd45);

      // Scenario 5: abort and start together at count 10.
      data_in = 6'h3C;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("ab_pre_count", 32'(count), 32'd10);
      abort   = 1'b1;
      start   = 1'b1;
      data_in = 6'h11;
      tick();
      abort   = 1'b0;
      start   = 1'b0;
      data_in = 6'h00;
      check("ab_running", 32'(running),  32'd0);
      check("ab_count",   32'(count),    32'd0);
      check("ab_done",    32'(done),     32'd0);
      check("ab_dout",    32'(data_out), 32'h07);
      check("ab_ser",     32'(ser_out),  32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("ab_idle_count", 32'(count),   32'd0);
         check("ab_idle_run",   32'(running), 32'd0);
      end

      // Scenario 6: asynchronous reset between edges mid-run.
      data_in = 6'h0F;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      check("ar_pre_count", 32'(count),   32'd7);
      check("ar_pre_ser",   32'(ser_out), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check("ar_count",   32'(count),    32'd0);
      check("ar_running", 32'(running),  32'd0);
      check("ar_done",    32'(done),     32'd0);
      check("ar_dout",    32'(data_out), 32'd0);
      check("ar_ser",     32'(ser_out),  32'd0);
      tick();
      check("ar_held_count", 32'(count), 32'd0);
      rst = 1'b0;
      tick();
      check("ar_idle_run", 32'(running), 32'd0);
      run_oneshot(6'h2A, 6'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
